// File: rtl/pwm_ticked.sv
// Tick-driven PWM with double-buffered period/duty and a wrap pulse.
// Define PWM_CENTER_EN for center-aligned (up/down) counting.
module pwm_ticked #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         tick,
  input  logic [W-1:0] period,
  input  logic [W-1:0] duty,
  input  logic         put,
  output logic         out,
  output logic         wrap,
  output logic [W-1:0] phase
);

  logic [W-1:0] act_p;
  logic [W-1:0] act_d;
  logic [W-1:0] pend_p;
  logic [W-1:0] pend_d;
  logic         pend_v;
  logic         run;
  logic         at_top;
  logic         roll;

  assign run    = act_p != '0;
  assign at_top = run && (phase == act_p - W'(1));
  assign out    = run && (phase < act_d);

`ifdef PWM_CENTER_EN
  logic dir;
  assign roll = run && tick && dir && (phase == '0);
`else
  assign roll = run && tick && at_top;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      act_p  <= '0;
      act_d  <= '0;
      pend_p <= '0;
      pend_d <= '0;
      pend_v <= 1'b0;
      phase  <= '0;
      wrap   <= 1'b0;
`ifdef PWM_CENTER_EN
      dir    <= 1'b0;
`endif
    end else begin
      wrap <= roll;
      if (!run) begin
        phase <= '0;
`ifdef PWM_CENTER_EN
        dir   <= 1'b0;
`endif
        if (put) begin
          act_p <= period;
          act_d <= duty;
        end
      end else begin
`ifdef PWM_CENTER_EN
        if (tick) begin
          if (!dir) begin
            if (at_top) dir <= 1'b1;
            else phase <= phase + W'(1);
          end else begin
            if (phase == '0) dir <= 1'b0;
            else phase <= phase - W'(1);
          end
        end
`else
        if (tick) phase <= at_top ? '0 : phase + W'(1);
`endif
        // A put landing on the rollover edge wins over any pending value
        if (roll) begin
          if (put) begin
            act_p <= period;
            act_d <= duty;
          end else if (pend_v) begin
            act_p <= pend_p;
            act_d <= pend_d;
          end
          pend_v <= 1'b0;
        end else if (put) begin
          pend_p <= period;
          pend_d <= duty;
          pend_v <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_ticked.sv
// Directed vector bench for pwm_ticked (edge-aligned build).
module tb_pwm_ticked;

  logic       clock = 1'b0;
  logic       reset;
  logic       tick;
  logic [7:0] period;
  logic [7:0] duty;
  logic       put;
  logic       out;
  logic       wrap;
  logic [7:0] phase;

  int total = 0;
  int bad   = 0;

  pwm_ticked #(.W(8)) dut (
    .clock (clock),
    .reset (reset),
    .tick  (tick),
    .period(period),
    .duty  (duty),
    .put   (put),
    .out   (out),
    .wrap  (wrap),
    .phase (phase)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       put;
    logic       tick;
    logic [7:0] p;
    logic [7:0] d;
    logic       eo;
    logic       ew;
    logic [7:0] eph;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(logic pu, logic tk, int p, int d,
                             logic eo, logic ew, int eph);
    vec_t r;
    r.put  = pu;
    r.tick = tk;
    r.p    = 8'(p);
    r.d    = 8'(d);
    r.eo   = eo;
    r.ew   = ew;
    r.eph  = 8'(eph);
    return r;
  endfunction

  task automatic chk(string nm, int idx, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0d, want %0d", nm, idx, act, exp);
    end
  endtask

  task automatic step(logic pu, logic tk, logic [7:0] p, logic [7:0] d);
    @(negedge clock);
    put    = pu;
    tick   = tk;
    period = p;
    duty   = d;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    tick   = 1'b0;
    put    = 1'b0;
    period = '0;
    duty   = '0;

    // load 4/1 and free-run
    vq.push_back(v(1,0,4,1, 1,0,0));
    vq.push_back(v(0,1,0,0, 0,0,1));
    vq.push_back(v(0,1,0,0, 0,0,2));
    vq.push_back(v(0,1,0,0, 0,0,3));
    vq.push_back(v(0,1,0,0, 1,1,0));
    vq.push_back(v(0,1,0,0, 0,0,1));
    // two pending puts; last one wins at rollover
    vq.push_back(v(1,0,4,2, 0,0,1));
    vq.push_back(v(0,1,0,0, 0,0,2));
    vq.push_back(v(1,0,4,3, 0,0,2));
    vq.push_back(v(0,1,0,0, 0,0,3));
    vq.push_back(v(0,1,0,0, 1,1,0));
    vq.push_back(v(0,1,0,0, 1,0,1));
    vq.push_back(v(0,1,0,0, 1,0,2));
    // pend 4/1, then put 4/2 on the rollover tick bypasses it
    vq.push_back(v(1,1,4,1, 0,0,3));
    vq.push_back(v(1,1,4,2, 1,1,0));
    vq.push_back(v(0,1,0,0, 1,0,1));
    vq.push_back(v(0,1,0,0, 0,0,2));
    vq.push_back(v(0,1,0,0, 0,0,3));
    vq.push_back(v(0,1,0,0, 1,1,0));
    vq.push_back(v(0,1,0,0, 1,0,1));
    vq.push_back(v(0,0,0,0, 1,0,1));
    // duty 0 -> stuck low
    vq.push_back(v(1,0,4,0, 1,0,1));
    vq.push_back(v(0,1,0,0, 0,0,2));
    vq.push_back(v(0,1,0,0, 0,0,3));
    vq.push_back(v(0,1,0,0, 0,1,0));
    vq.push_back(v(0,1,0,0, 0,0,1));
    // duty 9 > period 4 -> stuck high
    vq.push_back(v(1,0,4,9, 0,0,1));
    vq.push_back(v(0,1,0,0, 0,0,2));
    vq.push_back(v(0,1,0,0, 0,0,3));
    vq.push_back(v(0,1,0,0, 1,1,0));
    vq.push_back(v(0,1,0,0, 1,0,1));
    vq.push_back(v(0,1,0,0, 1,0,2));
    vq.push_back(v(0,1,0,0, 1,0,3));
    // period 1 -> wrap every tick
    vq.push_back(v(1,1,1,1, 1,1,0));
    vq.push_back(v(0,1,0,0, 1,1,0));
    vq.push_back(v(0,0,0,0, 1,0,0));
    vq.push_back(v(0,1,0,0, 1,1,0));
    // back to 4/2, then pend period 0 -> disabled after one wrap
    vq.push_back(v(1,0,4,2, 1,0,0));
    vq.push_back(v(0,1,0,0, 1,1,0));
    vq.push_back(v(0,1,0,0, 1,0,1));
    vq.push_back(v(1,0,0,0, 1,0,1));
    vq.push_back(v(0,1,0,0, 0,0,2));
    vq.push_back(v(0,1,0,0, 0,0,3));
    vq.push_back(v(0,1,0,0, 0,1,0));
    vq.push_back(v(0,1,0,0, 0,0,0));
    vq.push_back(v(0,1,0,0, 0,0,0));
    // put while disabled loads directly; tick ignored
    vq.push_back(v(1,1,3,2, 1,0,0));
    vq.push_back(v(0,1,0,0, 1,0,1));

    @(posedge clock);
    @(posedge clock);
    #1;
    chk("rst_out",   0, out,   0);
    chk("rst_wrap",  0, wrap,  0);
    chk("rst_phase", 0, phase, 0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].put, vq[i].tick, vq[i].p, vq[i].d);
      chk("out",   i, out,   vq[i].eo);
      chk("wrap",  i, wrap,  vq[i].ew);
      chk("phase", i, phase, vq[i].eph);
    end

    // reset mid-cycle with a pending update discards everything
    step(1'b1, 1'b1, 8'd5, 8'd5);
    chk("pre_phase", 0, phase, 2);
    @(negedge clock);
    reset = 1'b1;
    put   = 1'b0;
    tick  = 1'b1;
    @(posedge clock);
    #1;
    chk("mid_out",   0, out,   0);
    chk("mid_wrap",  0, wrap,  0);
    chk("mid_phase", 0, phase, 0);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 8'd0, 8'd0);
      chk("post_out",   k, out,   0);
      chk("post_wrap",  k, wrap,  0);
      chk("post_phase", k, phase, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
